muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter LATENCY, default 4, number of EXEC cycles the ALU is held before capture; legal range 1..15.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a mul/div operation; sampled only in IDLE or DONE.
REQ-006 op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 rs_val, rt_val  input  DATA_SIZE each  operands; rs is dividend/multiplicand, rt is divisor/multiplier.
REQ-008 mthi, mtlo  input  1 each  write wr_data into HI or LO.
REQ-009 wr_data  input  DATA_SIZE  data for mthi/mtlo.
REQ-010 alu_res1, alu_res2  input  DATA_SIZE each  ALU result ports 1 and 2.
REQ-011 alu_unvalid  input  1  ALU divide-by-zero flag.
REQ-012 alu_own  output  1  high while the block owns the shared ALU; the datapath mux routes alu_a/alu_b/alu_ctrl to the ALU when high.
REQ-013 alu_a, alu_b  output  DATA_SIZE each  registered operands to ALU SrcA/SrcB.
REQ-014 alu_ctrl  output  5  ALU function code.
REQ-015 busy  output  1  operation in progress; pipeline stalls on mfhi/mflo/mult/div while high.
REQ-016 done  output  1  one-cycle pulse: HI/LO updated or div-by-zero detected.
REQ-017 div_zero  output  1  sticky flag, last operation was a divide by zero.
REQ-018 hi, lo  output  DATA_SIZE each  architectural HI/LO registers.

Function
REQ-019 SHALL implement states IDLE, EXEC, DONE.
REQ-020 In IDLE or DONE, start=1 SHALL latch op, rs_val into alu_a, rt_val into alu_b, load counter with LATENCY-1, and enter EXEC; otherwise DONE returns to IDLE and IDLE holds.
REQ-021 In EXEC, busy=1, alu_own=1, and alu_ctrl SHALL be 9 (mult), 12 (multu), 10 (div) or 13 (divu) from the latched op.
REQ-022 Outside EXEC, alu_own=0, busy=0, and alu_ctrl=0.
REQ-023 In EXEC the counter SHALL decrement each cycle; at the edge where it equals 0 the block SHALL capture results and enter DONE.
REQ-024 Capture, mult/multu: hi<=alu_res1, lo<=alu_res2 (64-bit product upper/lower).
REQ-025 Capture, div/divu: lo<=alu_res2 (quotient), hi<=alu_res1 (remainder).
REQ-026 Capture with alu_unvalid=1 SHALL leave hi/lo unchanged and set div_zero=1; any capture with alu_unvalid=0 SHALL clear div_zero.
REQ-027 done SHALL be 1 exactly for the cycle in DONE.
REQ-028 Start sampled at cycle N SHALL give EXEC for cycles N+1..N+LATENCY and done=1 at N+LATENCY+1.
REQ-029 start during EXEC SHALL be ignored, with no queueing.
REQ-030 start in DONE SHALL be accepted, allowing back-to-back operations with one non-busy cycle between them.
REQ-031 mthi/mtlo SHALL write on the next edge only outside EXEC; during EXEC they SHALL be ignored.
REQ-032 If start and mthi/mtlo are both high in the same accepting cycle, both SHALL take effect; the later capture overwrites.
REQ-033 If mthi and mtlo are both high, both registers SHALL be written with wr_data.
REQ-034 alu_a/alu_b SHALL be stable throughout EXEC regardless of rs_val/rt_val changes.

Reset
REQ-035 RST=0 SHALL immediately force IDLE, counter=0, hi=0, lo=0, alu_a=0, alu_b=0, busy=0, done=0, div_zero=0, alu_own=0, alu_ctrl=0.
REQ-036 Reset mid-EXEC SHALL abort the operation with no capture and no done pulse.

Verification
REQ-037 mult, rs=0xFFFFFFFD, rt=5, LATENCY=4 -> alu_ctrl=9 for 4 cycles; done at start+5; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-038 multu, rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE; div_zero=0.
REQ-039 div, rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu rt=0 -> hi/lo unchanged, div_zero=1, done pulses.
REQ-040 start pulsed again and mthi=1 (wr_data=0x1234) during EXEC -> both ignored; single done; hi equals the product.
REQ-041 RST low at EXEC cycle 2 -> all outputs 0 at once; no done after release; next start completes normally.
REQ-042 start held high continuously with mtlo in IDLE (wr_data=0xAA) -> lo=0xAA until capture overwrites it; operations repeat every LATENCY+1 cycles.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide controller: borrows the shared ALU for LATENCY cycles,
// then captures the ALU result pair into the architectural HI/LO registers.
module muldiv_seq #(
  parameter int DATA_SIZE = 32,
  parameter int LATENCY   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [DATA_SIZE-1:0] rs_val,
  input  logic [DATA_SIZE-1:0] rt_val,
  input  logic                 mthi,
  input  logic                 mtlo,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [DATA_SIZE-1:0] alu_res1,
  input  logic [DATA_SIZE-1:0] alu_res2,
  input  logic                 alu_unvalid,
  output logic                 alu_own,
  output logic [DATA_SIZE-1:0] alu_a,
  output logic [DATA_SIZE-1:0] alu_b,
  output logic [4:0]           alu_ctrl,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic [DATA_SIZE-1:0] hi,
  output logic [DATA_SIZE-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] count;
  logic [3:0] count_next;
  logic [1:0] op_q;
  logic       accept;
  logic       capture;
  logic [4:0] ctrl_next;

  function automatic logic [4:0] ctrl_code(input logic [1:0] sel);
    case (sel)
      2'b00:   ctrl_code = 5'd9;
      2'b01:   ctrl_code = 5'd12;
      2'b10:   ctrl_code = 5'd10;
      2'b11:   ctrl_code = 5'd13;
      default: ctrl_code = 5'd0;
    endcase
  endfunction

  // State and cycle counter registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state, counter and control strobes
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    capture    = 1'b0;
    ctrl_next  = 5'd0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = EXEC;
          count_next = COUNT_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        if (count == 4'd0) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          count_next = count - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
    if (state_next == EXEC) begin
      ctrl_next = ctrl_code(accept ? op : op_q);
    end else begin
      ctrl_next = 5'd0;
    end
  end

  // Status outputs are registered from the next state so they track it exactly
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy     <= 1'b0;
      alu_own  <= 1'b0;
      done     <= 1'b0;
      alu_ctrl <= 5'd0;
    end else begin
      busy     <= (state_next == EXEC);
      alu_own  <= (state_next == EXEC);
      done     <= (state_next == DONE);
      alu_ctrl <= ctrl_next;
    end
  end

  // Operand latch; held for the whole EXEC window
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_a <= {DATA_SIZE{1'b0}};
      alu_b <= {DATA_SIZE{1'b0}};
      op_q  <= 2'd0;
    end else if (accept) begin
      alu_a <= rs_val;
      alu_b <= rt_val;
      op_q  <= op;
    end
  end

  // HI/LO: capture only happens in EXEC and moves only happen outside it, so they never collide
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi       <= {DATA_SIZE{1'b0}};
      lo       <= {DATA_SIZE{1'b0}};
      div_zero <= 1'b0;
    end else if (capture) begin
      if (alu_unvalid) begin
        div_zero <= 1'b1;
      end else begin
        hi       <= alu_res1;
        lo       <= alu_res2;
        div_zero <= 1'b0;
      end
    end else if (state != EXEC) begin
      if (mthi) hi <= wr_data;
      if (mtlo) lo <= wr_data;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed operations push expected HI/LO/div_zero,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] alu_res1;
  logic [31:0] alu_res2;
  logic        alu_unvalid;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_ctrl;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;
  exp_t sb[$];

  muldiv_seq #(.DATA_SIZE(32), .LATENCY(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .alu_res1(alu_res1), .alu_res2(alu_res2),
    .alu_unvalid(alu_unvalid), .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  // Shared ALU model: res1 = product high / remainder, res2 = product low / quotient
  logic [63:0] prod;
  always_comb begin
    prod        = 64'd0;
    alu_res1    = 32'd0;
    alu_res2    = 32'd0;
    alu_unvalid = 1'b0;
    case (alu_ctrl)
      5'd9: begin
        prod = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
        alu_res1 = prod[63:32];
        alu_res2 = prod[31:0];
      end
      5'd12: begin
        prod = {32'd0, alu_a} * {32'd0, alu_b};
        alu_res1 = prod[63:32];
        alu_res2 = prod[31:0];
      end
      5'd10: begin
        if (alu_b == 32'd0) alu_unvalid = 1'b1;
        else begin
          alu_res2 = $signed(alu_a) / $signed(alu_b);
          alu_res1 = $signed(alu_a) % $signed(alu_b);
        end
      end
      5'd13: begin
        if (alu_b == 32'd0) alu_unvalid = 1'b1;
        else begin
          alu_res2 = alu_a / alu_b;
          alu_res1 = alu_a % alu_b;
        end
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry
  always @(negedge CLK) begin
    if (RST && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_hi", {32'd0, hi}, {32'd0, e.hi});
        check("sb_lo", {32'd0, lo}, {32'd0, e.lo});
        check("sb_div_zero", {63'd0, div_zero}, {63'd0, e.dz});
      end
    end
  end

  task automatic push(input logic [31:0] h, input logic [31:0] l, input logic z);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = z;
    sb.push_back(e);
  endtask

  // One operation; optional injection of a start/mthi pulse and operand change during EXEC
  task automatic run_op(input logic [1:0] o, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] ctrl, input bit inject);
    @(negedge CLK);
    start = 1'b1; op = o; rs_val = rs; rt_val = rt;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("exec_ctrl", {59'd0, alu_ctrl}, {59'd0, ctrl});
      check("exec_busy_own", {62'd0, busy, alu_own}, {62'd0, 2'b11});
      check("exec_alu_a", {32'd0, alu_a}, {32'd0, rs});
      check("exec_alu_b", {32'd0, alu_b}, {32'd0, rt});
      check("exec_no_done", {63'd0, done}, 64'd0);
      if (inject && i == 0) begin
        start = 1'b1; mthi = 1'b1; wr_data = 32'h0000_1234; rs_val = ~rs; rt_val = 32'd99;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      @(negedge CLK);
    end
    check("done_pulse", {63'd0, done}, 64'd1);
    check("done_idle_outs", {57'd0, busy, alu_own, alu_ctrl}, 64'd0);
  endtask

  initial begin
    #12;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_alu_ab", {alu_a, alu_b}, 64'd0);
    check("reset_ctrl", {55'd0, busy, done, div_zero, alu_own, alu_ctrl}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 5'd9, 1'b0);
    push(32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd12, 1'b0);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    run_op(2'b11, 32'd100, 32'd0, 5'd13, 1'b0);

    // Simultaneous mthi/mtlo in IDLE write both; div_zero untouched
    @(negedge CLK);
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h5A5A_5A5A;
    @(negedge CLK);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_both", {hi, lo}, {32'h5A5A_5A5A, 32'h5A5A_5A5A});
    check("mthilo_dz_kept", {63'd0, div_zero}, 64'd1);

    // start + mthi during EXEC ignored
    push(32'd0, 32'd21, 1'b0);
    run_op(2'b00, 32'd3, 32'd7, 5'd9, 1'b1);
    repeat (6) begin
      @(negedge CLK);
      check("no_requeue", {62'd0, busy, done}, 64'd0);
    end
    check("hi_is_product", {32'd0, hi}, 64'd0);

    // Reset during EXEC cycle 2
    @(negedge CLK);
    start = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_exec_hilo", {hi, lo}, 64'd0);
    check("rst_exec_ab", {alu_a, alu_b}, 64'd0);
    check("rst_exec_ctrl", {55'd0, busy, done, div_zero, alu_own, alu_ctrl}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      check("rst_no_done", {62'd0, busy, done}, 64'd0);
    end
    push(32'd0, 32'd42, 1'b0);
    run_op(2'b00, 32'd6, 32'd7, 5'd9, 1'b0);

    // start held high with mtlo in the accepting IDLE cycle: back-to-back every 5 cycles
    push(32'd0, 32'h30, 1'b0);
    push(32'd0, 32'h30, 1'b0);
    push(32'd0, 32'h30, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    start = 1'b1; op = 2'b01; rs_val = 32'h10; rt_val = 32'd3; mtlo = 1'b1; wr_data = 32'hAA;
    @(negedge CLK);
    mtlo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_busy", {63'd0, busy}, 64'd1);
        check("b2b_lo", {32'd0, lo}, (k == 0) ? 64'hAA : 64'h30);
        @(negedge CLK);
      end
      check("b2b_done", {62'd0, done, busy}, 64'd2);
      if (k == 2) start = 1'b0;
      @(negedge CLK);
    end
    check("b2b_idle", {62'd0, busy, done}, 64'd0);

    repeat (3) @(negedge CLK);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
